// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states, slice width, add/sub op encoding.
// Helper functions size the slice counter from the datapath width.
package alu_pkg;

  localparam int SLICE = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int slice_count(input int width);
    return width / SLICE;
  endfunction

  // Counter needs at least one bit even when a single slice covers the word.
  function automatic int count_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add32_seq_if.sv
// Request/result bundle for the sequential adder; flag signals exist only
// when ADD32_SEQ_FLAGS_EN is defined.
interface add32_seq_if #(
  parameter int WIDTH = 32
);

  logic             i_start;
  logic             i_op_sub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_s;
  logic             o_co;

`ifdef ADD32_SEQ_FLAGS_EN
  logic o_n;
  logic o_z;
  logic o_v;

  modport master (
    output i_start, i_op_sub, i_a, i_b,
    input  o_busy, o_done, o_s, o_co, o_n, o_z, o_v
  );

  modport slave (
    input  i_start, i_op_sub, i_a, i_b,
    output o_busy, o_done, o_s, o_co, o_n, o_z, o_v
  );
`else
  modport master (
    output i_start, i_op_sub, i_a, i_b,
    input  o_busy, o_done, o_s, o_co
  );

  modport slave (
    input  i_start, i_op_sub, i_a, i_b,
    output o_busy, o_done, o_s, o_co
  );
`endif

endinterface

// File: rtl/add_slice4.sv
// 4-bit ripple adder slice built from full-adder cells; c3 is the carry into bit 3.
// Purely combinational, no handshake.
module add_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/fa_cell.sv
// Single-bit full adder cell.
// Purely combinational, no handshake.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add32_seq.sv
// Multi-cycle WIDTH-bit add/sub reusing one 4-bit slice per cycle, LSB first (ADD32_SEQ_FLAGS_EN adds N/Z/V).
// Latency: o_done pulses WIDTH/SLICE cycles after accept (8 at defaults).
// Backpressure: i_start is only accepted in IDLE or DONE; requests while busy are dropped.
module add32_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  add32_seq_if.slave  bus
);

  localparam int            NSL  = slice_count(WIDTH);
  localparam int            CW   = count_bits(NSL);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_q;
  logic             co_q;

  logic             accept;
  logic             step;
  logic             last;
  logic [SLICE-1:0] op_a;
  logic [SLICE-1:0] op_b;
  logic [SLICE-1:0] s4;
  logic             c_out;
  logic             c3;
  logic [WIDTH-1:0] res_nxt;

  assign last = (count == LAST);
  assign op_a = a_q[int'(count)*SLICE +: SLICE];
  assign op_b = bx_q[int'(count)*SLICE +: SLICE];

  add_slice4 u_slice (
    .a  (op_a),
    .b  (op_b),
    .ci (carry_q),
    .s  (s4),
    .co (c_out),
    .c3 (c3)
  );

  // Result word as it will look after this cycle's slice is written back.
  always_comb begin
    res_nxt = s_q;
    res_nxt[int'(count)*SLICE +: SLICE] = s4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_start) begin
          accept    = 1'b1;
          state_nxt = ST_ADD;
        end
      end
      ST_ADD: begin
        step = 1'b1;
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_start) begin
          accept    = 1'b1;
          state_nxt = ST_ADD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Subtract is a + ~b + 1: invert b once on accept and seed the carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      a_q     <= bus.i_a;
      bx_q    <= bus.i_b ^ {WIDTH{bus.i_op_sub == OP_SUB}};
      carry_q <= (bus.i_op_sub != OP_ADD);
    end else if (step) begin
      count   <= count + 1'b1;
      s_q     <= res_nxt;
      carry_q <= c_out;
      if (last) begin
        co_q <= c_out;
      end
    end
  end

`ifdef ADD32_SEQ_FLAGS_EN
  logic n_q;
  logic z_q;
  logic v_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
    end else if (step && last) begin
      n_q <= res_nxt[WIDTH-1];
      z_q <= (res_nxt == '0);
      v_q <= c3 ^ c_out;
    end
  end

  assign bus.o_n = n_q;
  assign bus.o_z = z_q;
  assign bus.o_v = v_q;
`else
  logic unused_c3;
  assign unused_c3 = c3;
`endif

  assign bus.o_busy = (state == ST_ADD);
  assign bus.o_done = (state == ST_DONE);
  assign bus.o_s    = s_q;
  assign bus.o_co   = co_q;

endmodule

// File: tb/tb_add32_seq.sv
// Directed bench for add32_seq: latency, add/sub results, ignored requests,
// reset abort and back-to-back accept.
module tb_add32_seq;
  import alu_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  add32_seq_if #(.WIDTH(32)) bus ();

  add32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] s, input logic co,
                           input logic n, input logic z, input logic v);
    check({tag, ".s"},  bus.o_s,  s);
    check({tag, ".co"}, bus.o_co, co);
`ifdef ADD32_SEQ_FLAGS_EN
    check({tag, ".n"}, bus.o_n, n);
    check({tag, ".z"}, bus.o_z, z);
    check({tag, ".v"}, bus.o_v, v);
`else
    if (n === 1'bx || z === 1'bx || v === 1'bx) $display("note: %s flag arg unknown", tag);
`endif
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.i_a      = a;
    bus.i_b      = b;
    bus.i_op_sub = sub;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start  = 1'b0;
  endtask

  // Advances negedge by negedge until o_done, bounded.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (bus.o_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) seen++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] s, input logic co,
                        input logic n, input logic z, input logic v);
    int lat;
    issue(a, b, sub);
    check({tag, ".busy"}, bus.o_busy, 1'b1);
    wait_done(0, lat);
    check({tag, ".lat"}, lat, 8);
    check_res(tag, s, co, n, z, v);
    @(negedge clk);
    check({tag, ".pulse"}, bus.o_done, 1'b0);
    check({tag, ".hold"},  bus.o_s,    s);
  endtask

  initial begin
    int lat;
    int seen;

    bus.i_start  = 1'b0;
    bus.i_op_sub = OP_ADD;
    bus.i_a      = '0;
    bus.i_b      = '0;

    repeat (2) @(negedge clk);
    check("rst.busy", bus.o_busy, 1'b0);
    check("rst.done", bus.o_done, 1'b0);
    check_res("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("t1", 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("t2", 32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("t3", 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);

    // Request while busy must not disturb the running operation.
    issue(32'h1234_5678, 32'h1111_1111, OP_ADD);
    repeat (2) @(negedge clk);
    bus.i_a      = 32'hFFFF_FFFF;
    bus.i_b      = 32'hFFFF_FFFF;
    bus.i_op_sub = OP_SUB;
    bus.i_start  = 1'b1;
    @(negedge clk);
    bus.i_start  = 1'b0;
    check("t4.busy", bus.o_busy, 1'b1);
    wait_done(3, lat);
    check("t4.lat", lat, 8);
    check_res("t4", 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
    count_dones(12, seen);
    check("t4.extra_done", seen, 0);
    check("t4.idle", bus.o_busy, 1'b0);

    // Asynchronous reset in the middle of an operation.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_ADD);
    repeat (3) @(negedge clk);
    check("t5.busy_pre", bus.o_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t5.busy", bus.o_busy, 1'b0);
    check("t5.done", bus.o_done, 1'b0);
    check("t5.s",    bus.o_s,    32'h0);
    check("t5.co",   bus.o_co,   1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    count_dones(12, seen);
    check("t5.no_done", seen, 0);
    run_op("t5b", 32'h0000_0003, 32'h0000_0004, OP_ADD, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);

    // i_start held through DONE: second request accepted with no IDLE gap.
    bus.i_a      = 32'hAAAA_AAAA;
    bus.i_b      = 32'h5555_5555;
    bus.i_op_sub = OP_ADD;
    bus.i_start  = 1'b1;
    @(negedge clk);
    check("t6.busy_a", bus.o_busy, 1'b1);
    wait_done(0, lat);
    check("t6.lat_a", lat, 8);
    check_res("t6a", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.i_a      = 32'h0000_0010;
    bus.i_b      = 32'h0000_0001;
    bus.i_op_sub = OP_SUB;
    @(negedge clk);
    check("t6.busy_b", bus.o_busy, 1'b1);
    bus.i_start  = 1'b0;
    wait_done(0, lat);
    check("t6.lat_b", lat, 8);
    check_res("t6b", 32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6.pulse", bus.o_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
